mem_lsu_stage: RTL

Parametrised memory-access pipeline stage for the five-stage MIPS core, sitting between the EX/MEM and MEM/WB boundaries. It decodes load and store opcodes from the instruction word and builds byte enables and lane-shifted store data. It drives a variable-latency data-memory request/grant/response port, extends load data, detects address-alignment faults and bus timeouts, and registers the result into the WB pipeline register. It replaces the fixed single-cycle DM path with a stalling handshake.

---
 rtl/mem_lsu_stage.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu_stage.sv
// Memory-access pipeline stage: decodes loads/stores, drives a variable-latency
// request/grant/response data-memory port, extends load data, flags alignment
// faults and bus timeouts, and registers the result into the WB register.
module mem_lsu_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_byteen,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              ld_pending,
  output logic [4:0]        ld_rt,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_data,
  output logic [1:0]        out_exc
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_DBE  = 2'b11;

  // Wide enough to hold TIMEOUT itself (the counter can reach it in RESP).
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         hold_pc, hold_instr, hold_wdata;
  logic [ADDR_W-1:0]   hold_addr;

  logic [5:0]          in_op, hold_op;
  logic                in_load, in_mem, in_fault, in_accept_mem;
  logic                hold_load, hold_store;
  logic                tmo;
  logic [31:0]         alu_res;
  logic [3:0]          st_byteen;
  logic [31:0]         st_wdata;

  logic                wb_en;
  logic [31:0]         wb_pc, wb_instr, wb_data;
  logic [1:0]          wb_exc;

  // ALU result seen as a 32-bit writeback value regardless of address width.
  if (ADDR_W >= 32) begin : g_alu_wide
    assign alu_res = in_addr[31:0];
  end else begin : g_alu_narrow
    assign alu_res = {{(32-ADDR_W){1'b0}}, in_addr};
  end

  assign in_op         = in_instr[31:26];
  assign in_load       = is_load(in_op);
  assign in_mem        = in_load | is_store(in_op);
  assign in_fault      = in_mem & is_misaligned(in_op, in_addr[1:0]);
  assign in_accept_mem = in_valid & in_mem & ~in_fault;

  assign hold_op    = hold_instr[31:26];
  assign hold_load  = is_load(hold_op);
  assign hold_store = is_store(hold_op);

  assign tmo = (TIMEOUT != 0) && (32'(cnt_q) >= 32'(TIMEOUT - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: grant/response take priority over the timeout.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_accept_mem) state_d = S_REQ;
      S_REQ: begin
        if (dm_gnt)   state_d = hold_store ? S_IDLE : S_RESP;
        else if (tmo) state_d = S_IDLE;
      end
      S_RESP: if (dm_rvalid || tmo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store lane steering from the held address and rt value.
  always_comb begin
    st_byteen = 4'b0000;
    st_wdata  = 32'h0;
    case (hold_op)
      OP_SB: begin
        st_byteen = 4'b0001 << hold_addr[1:0];
        st_wdata  = {4{hold_wdata[7:0]}};
      end
      OP_SH: begin
        st_byteen = hold_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{hold_wdata[15:0]}};
      end
      OP_SW: begin
        st_byteen = 4'b1111;
        st_wdata  = hold_wdata;
      end
      default: ;
    endcase
  end

  // Output logic: memory port, hazard outputs and the WB load request.
  always_comb begin
    in_ready   = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_byteen  = 4'b0000;
    dm_wdata   = 32'h0;
    ld_pending = (state_q != S_IDLE) && hold_load;
    ld_rt      = hold_instr[20:16];
    wb_en      = 1'b0;
    wb_pc      = hold_pc;
    wb_instr   = hold_instr;
    wb_data    = 32'h0;
    wb_exc     = EXC_NONE;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !in_accept_mem) begin
          wb_en    = 1'b1;
          wb_pc    = in_pc;
          wb_instr = in_instr;
          wb_data  = in_mem ? 32'h0 : alu_res;
          wb_exc   = !in_fault ? EXC_NONE : (in_load ? EXC_ADEL : EXC_ADES);
        end
      end
      S_REQ: begin
        dm_req    = 1'b1;
        dm_we     = hold_store;
        dm_addr   = {hold_addr[ADDR_W-1:2], 2'b00};
        dm_byteen = st_byteen;
        dm_wdata  = st_wdata;
        if (dm_gnt) begin
          wb_en = hold_store;
        end else if (tmo) begin
          wb_en  = 1'b1;
          wb_exc = EXC_DBE;
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          wb_en   = 1'b1;
          wb_data = load_extend(hold_op, hold_addr[1:0], dm_rdata);
        end else if (tmo) begin
          wb_en  = 1'b1;
          wb_exc = EXC_DBE;
        end
      end
      default: ;
    endcase
  end

  // Hold registers capture an accepted memory operation for the whole transaction.
  // NOTE: the hold registers are reset, not left undefined, because dm_* lanes
  // and ld_rt are decoded from them and must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      hold_addr  <= '0;
      hold_wdata <= 32'h0;
    end else if (in_accept_mem) begin
      hold_pc    <= in_pc;
      hold_instr <= in_instr;
      hold_addr  <= in_addr;
      hold_wdata <= in_wdata;
    end
  end

  // Timeout counter: cleared on entry to REQ, counts every REQ/RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    cnt_q <= '0;
    else if (in_accept_mem && state_q == S_IDLE) cnt_q <= '0;
    else if (state_q != S_IDLE && TIMEOUT != 0)  cnt_q <= cnt_q + CNT_ONE;
  end

  // WB pipeline register: one-cycle valid pulse, payload held until next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_instr <= 32'h0;
      out_data  <= 32'h0;
      out_exc   <= EXC_NONE;
    end else begin
      out_valid <= wb_en;
      if (wb_en) begin
        out_pc    <= wb_pc;
        out_instr <= wb_instr;
        out_data  <= wb_data;
        out_exc   <= wb_exc;
      end
    end
  end

endmodule
